// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the HDMI PLL reconfiguration writer: register map,
// counter-word bit fields and the sequencer state encoding.
package pll_cfg_pkg;

  localparam logic [5:0] ADDR_MODE  = 6'h00;
  localparam logic [5:0] ADDR_START = 6'h02;
  localparam logic [5:0] ADDR_N     = 6'h03;
  localparam logic [5:0] ADDR_M     = 6'h04;
  localparam logic [5:0] ADDR_C     = 6'h05;
  localparam logic [5:0] ADDR_K     = 6'h07;

  localparam int BIT_BYPASS = 17;
  localparam int BIT_ODD    = 16;
  localparam int CSEL_LSB   = 18;
  localparam int CSEL_MSB   = 22;

  // Consecutive locked cycles required before the relock is accepted.
  localparam logic [1:0] LOCK_RUN_LAST = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_WR_MODE,
    S_WR_N,
    S_WR_M,
    S_WR_C,
    S_WR_K,
    S_WR_START,
    S_WAIT_UNLOCK,
    S_WAIT_LOCK,
    S_DONE,
    S_ERR
  } state_e;

endpackage

// File: rtl/pll_div_encode.sv
// Maps a divide value onto the PLL counter register word (high/low/odd/bypass
// fields) and places the output-counter select in the C-select field.
module pll_div_encode
  import pll_cfg_pkg::*;
(
  input  logic [7:0]  div_i,
  input  logic [4:0]  csel_i,
  output logic [31:0] word_o
);

  always_comb begin
    word_o = '0;
    if (div_i == 8'd1) begin
      word_o[BIT_BYPASS] = 1'b1;
    end else begin
      // high = ceil(d/2), low = floor(d/2); 255 gives 128/127, so 8 bits suffice
      word_o[15:8]    = {1'b0, div_i[7:1]} + {7'd0, div_i[0]};
      word_o[7:0]     = {1'b0, div_i[7:1]};
      word_o[BIT_ODD] = div_i[0];
    end
    word_o[CSEL_MSB:CSEL_LSB] = csel_i;
  end

endmodule

// File: rtl/hdmi_pll_cfg_writer.sv
// Avalon-MM reconfiguration master for the fractional HDMI video PLL: writes the
// encoded divider set, triggers reconfiguration and supervises relock.
//
// state         | meaning
// IDLE          | waiting for cfg_req; request latched on accept
// CHECK         | reject zero divide values before touching the bus
// WR_MODE       | write waitrequest mode (addr 0x00)
// WR_N/M/C/K    | write N, M, C0 and M-fraction words
// WR_START      | write start (addr 0x02), kicks off reconfiguration
// WAIT_UNLOCK   | wait for lock to drop, or give up after UNLOCK_WAIT cycles
// WAIT_LOCK     | need 4 consecutive locked cycles before LOCK_TIMEOUT
// DONE          | one-cycle cfg_done pulse
// ERR           | one-cycle error state, cfg_err stays set
module hdmi_pll_cfg_writer
  import pll_cfg_pkg::*;
#(
  parameter int unsigned LOCK_TIMEOUT = 2000000,
  parameter int unsigned UNLOCK_WAIT  = 256,
  parameter int unsigned C_INDEX      = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_req,
  input  logic [7:0]  cfg_n,
  input  logic [7:0]  cfg_m,
  input  logic [7:0]  cfg_c,
  input  logic [31:0] cfg_k,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        mgmt_write,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked
);

  localparam logic [31:0] UNLOCK_LOAD = 32'(UNLOCK_WAIT - 1);
  localparam logic [31:0] LOCK_LOAD   = 32'(LOCK_TIMEOUT - 1);
  localparam logic [4:0]  CSEL        = 5'(C_INDEX);

  state_e      state_q;
  logic [7:0]  n_q, m_q, c_q;
  logic [31:0] k_q;
  logic [31:0] cnt_q;
  logic [1:0]  run_q;
  logic        busy_q, done_q, err_q, wr_q;
  logic [5:0]  addr_q;
  logic [31:0] data_q;

  logic [31:0] n_word, m_word, c_word;
  state_e      wr_state_d;
  logic [5:0]  wr_addr_d;
  logic [31:0] wr_data_d;

  pll_div_encode u_enc_n (.div_i(n_q), .csel_i(5'd0), .word_o(n_word));
  pll_div_encode u_enc_m (.div_i(m_q), .csel_i(5'd0), .word_o(m_word));
  pll_div_encode u_enc_c (.div_i(c_q), .csel_i(CSEL), .word_o(c_word));

  // Write that follows the current state once the bus accepts it.
  always_comb begin
    wr_state_d = S_IDLE;
    wr_addr_d  = '0;
    wr_data_d  = '0;
    case (state_q)
      S_CHECK:   begin wr_state_d = S_WR_MODE;  wr_addr_d = ADDR_MODE;  end
      S_WR_MODE: begin wr_state_d = S_WR_N;     wr_addr_d = ADDR_N;     wr_data_d = n_word; end
      S_WR_N:    begin wr_state_d = S_WR_M;     wr_addr_d = ADDR_M;     wr_data_d = m_word; end
      S_WR_M:    begin wr_state_d = S_WR_C;     wr_addr_d = ADDR_C;     wr_data_d = c_word; end
      S_WR_C:    begin wr_state_d = S_WR_K;     wr_addr_d = ADDR_K;     wr_data_d = k_q;    end
      S_WR_K:    begin wr_state_d = S_WR_START; wr_addr_d = ADDR_START; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      m_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      run_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cfg_req) begin
            n_q     <= cfg_n;
            m_q     <= cfg_m;
            c_q     <= cfg_c;
            k_q     <= cfg_k;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (n_q == 8'd0 || m_q == 8'd0 || c_q == 8'd0) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_ERR;
          end else begin
            wr_q    <= 1'b1;
            addr_q  <= wr_addr_d;
            data_q  <= wr_data_d;
            state_q <= wr_state_d;
          end
        end
        S_WR_MODE, S_WR_N, S_WR_M, S_WR_C, S_WR_K: begin
          if (!mgmt_waitrequest) begin
            addr_q  <= wr_addr_d;
            data_q  <= wr_data_d;
            state_q <= wr_state_d;
          end
        end
        S_WR_START: begin
          if (!mgmt_waitrequest) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= UNLOCK_LOAD;
            state_q <= S_WAIT_UNLOCK;
          end
        end
        S_WAIT_UNLOCK: begin
          if (!pll_locked || cnt_q == 32'd0) begin
            cnt_q   <= LOCK_LOAD;
            run_q   <= '0;
            state_q <= S_WAIT_LOCK;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        S_WAIT_LOCK: begin
          // A completed lock run takes priority over the timeout in the same cycle.
          if (pll_locked && run_q == LOCK_RUN_LAST) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else if (cnt_q == 32'd0) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_ERR;
          end else begin
            cnt_q <= cnt_q - 32'd1;
            run_q <= pll_locked ? run_q + 2'd1 : 2'd0;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cfg_busy       = busy_q;
  assign cfg_done       = done_q;
  assign cfg_err        = err_q;
  assign mgmt_write     = wr_q;
  assign mgmt_address   = addr_q;
  assign mgmt_writedata = data_q;

endmodule

// File: tb/tb_hdmi_pll_cfg_writer.sv
// Scoreboard bench for hdmi_pll_cfg_writer: expected bus writes are queued at
// request time and retired as the Avalon writes complete.
module tb_hdmi_pll_cfg_writer;

  localparam int UW = 16;
  localparam int LT = 200;
  localparam int CI = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_req = 1'b0;
  logic [7:0]  cfg_n = '0, cfg_m = '0, cfg_c = '0;
  logic [31:0] cfg_k = '0;
  logic        cfg_busy, cfg_done, cfg_err;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        mgmt_write;
  logic        mgmt_waitrequest = 1'b0;
  logic        pll_locked = 1'b1;

  hdmi_pll_cfg_writer #(.LOCK_TIMEOUT(LT), .UNLOCK_WAIT(UW), .C_INDEX(CI)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_req(cfg_req),
    .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_c(cfg_c), .cfg_k(cfg_k),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata),
    .mgmt_write(mgmt_write), .mgmt_waitrequest(mgmt_waitrequest),
    .pll_locked(pll_locked)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         sb[$];
  int          checks = 0;
  int          errors = 0;
  int          stall_len = 0;
  int          stall_cnt = 0;
  int          wr_cycles = 0;
  int          done_cnt = 0;
  logic        held = 1'b0;
  logic [5:0]  h_a = '0;
  logic [31:0] h_d = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int d, input int csel);
    int w;
    if (d == 1) w = 32'h0002_0000;
    else w = (((d + 1) / 2) << 8) | (d / 2) | ((d % 2) << 16);
    return 32'(w | (csel << 18));
  endfunction

  task automatic push_seq(input int n, input int m, input int c, input logic [31:0] k);
    sb.push_back('{a: 6'h00, d: 32'h0});
    sb.push_back('{a: 6'h03, d: enc(n, 0)});
    sb.push_back('{a: 6'h04, d: enc(m, 0)});
    sb.push_back('{a: 6'h05, d: enc(c, CI)});
    sb.push_back('{a: 6'h07, d: k});
    sb.push_back('{a: 6'h02, d: 32'h0});
  endtask

  // Avalon slave model: stalls each write stall_len cycles, checks stability and order.
  always @(negedge clk) begin
    wr_t e;
    if (cfg_done) done_cnt++;
    if (mgmt_write) begin
      wr_cycles++;
      if (held) begin
        check_eq("addr_stable", 32'(mgmt_address), 32'(h_a));
        check_eq("data_stable", mgmt_writedata, h_d);
      end
      if (stall_cnt < stall_len) begin
        mgmt_waitrequest = 1'b1;
        stall_cnt++;
        held = 1'b1;
        h_a = mgmt_address;
        h_d = mgmt_writedata;
      end else begin
        mgmt_waitrequest = 1'b0;
        stall_cnt = 0;
        held = 1'b0;
        if (sb.size() == 0) begin
          check_eq("unexpected_write_addr", 32'(mgmt_address), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check_eq("wr_addr", 32'(mgmt_address), 32'(e.a));
          check_eq("wr_data", mgmt_writedata, e.d);
        end
      end
    end else begin
      mgmt_waitrequest = 1'b0;
      stall_cnt = 0;
      held = 1'b0;
    end
  end

  task automatic do_req(input int n, input int m, input int c, input logic [31:0] k,
                        input bit expect_writes);
    @(negedge clk);
    wr_cycles = 0;
    done_cnt = 0;
    cfg_n = 8'(n);
    cfg_m = 8'(m);
    cfg_c = 8'(c);
    cfg_k = k;
    cfg_req = 1'b1;
    if (expect_writes) push_seq(n, m, c, k);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cfg_busy) break;
    end
    if (!cfg_busy) check_eq("accept_timeout", 32'(cfg_busy), 32'd1);
    cfg_req = 1'b0;
  endtask

  // Returns at the first negedge where mgmt_write has fallen after the write burst.
  task automatic seq_end();
    for (int i = 0; i < 50; i++) begin
      if (mgmt_write) break;
      @(negedge clk);
    end
    if (!mgmt_write) check_eq("write_start_timeout", 32'(mgmt_write), 32'd1);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!mgmt_write) break;
    end
    if (mgmt_write) check_eq("write_end_timeout", 32'(mgmt_write), 32'd0);
  endtask

  task automatic wait_flag(output int lat);
    lat = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      lat++;
      if (cfg_done || cfg_err) break;
    end
    if (!(cfg_done || cfg_err)) check_eq("flag_timeout", 32'(cfg_done | cfg_err), 32'd1);
  endtask

  task automatic lock_bounce();
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    pll_locked = 1'b1;
  endtask

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    check_eq("rst_write", 32'(mgmt_write), 32'd0);
    check_eq("rst_busy", 32'(cfg_busy), 32'd0);
    check_eq("rst_done", 32'(cfg_done), 32'd0);
    check_eq("rst_err", 32'(cfg_err), 32'd0);
    check_eq("rst_addr", 32'(mgmt_address), 32'd0);
    check_eq("rst_data", mgmt_writedata, 32'd0);
    rst_n = 1'b1;

    // Nominal sequence, no stalls, lock drops and returns.
    stall_len = 0;
    do_req(2, 74, 25, 32'h8000_0000, 1'b1);
    seq_end();
    check_eq("t1_wr_cycles", 32'(wr_cycles), 32'd6);
    lock_bounce();
    wait_flag(lat);
    check_eq("t1_done", 32'(cfg_done), 32'd1);
    check_eq("t1_busy_in_done", 32'(cfg_busy), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("t1_done_pulses", 32'(done_cnt), 32'd1);
    check_eq("t1_err", 32'(cfg_err), 32'd0);
    check_eq("t1_sb_empty", 32'(sb.size()), 32'd0);

    // Stalled writes; lock never drops so relock waits out UNLOCK_WAIT then 4 locked cycles.
    stall_len = 3;
    do_req(2, 74, 25, 32'h8000_0000, 1'b1);
    seq_end();
    check_eq("t2_wr_cycles", 32'(wr_cycles), 32'd24);
    wait_flag(lat);
    check_eq("t2_done_latency", 32'(lat), 32'(UW + 4));
    check_eq("t2_done", 32'(cfg_done), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("t2_done_pulses", 32'(done_cnt), 32'd1);
    check_eq("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Bypass and maximum divide encodings.
    stall_len = 0;
    do_req(1, 255, 1, 32'h0000_0001, 1'b1);
    seq_end();
    lock_bounce();
    wait_flag(lat);
    check_eq("t3_done", 32'(cfg_done), 32'd1);
    check_eq("t3_sb_empty", 32'(sb.size()), 32'd0);

    // Zero divide: error with no bus activity.
    do_req(2, 74, 0, 32'h0, 1'b0);
    wait_flag(lat);
    check_eq("t4_err", 32'(cfg_err), 32'd1);
    check_eq("t4_busy", 32'(cfg_busy), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("t4_wr_cycles", 32'(wr_cycles), 32'd0);
    check_eq("t4_err_sticky", 32'(cfg_err), 32'd1);
    check_eq("t4_no_done", 32'(done_cnt), 32'd0);

    // Lock never returns: one WAIT_UNLOCK cycle plus LOCK_TIMEOUT WAIT_LOCK cycles.
    do_req(2, 74, 25, 32'h1234_5678, 1'b1);
    seq_end();
    pll_locked = 1'b0;
    wait_flag(lat);
    check_eq("t5_err_latency", 32'(lat), 32'(LT + 1));
    check_eq("t5_err", 32'(cfg_err), 32'd1);
    check_eq("t5_busy", 32'(cfg_busy), 32'd0);
    check_eq("t5_no_done", 32'(done_cnt), 32'd0);

    // Next request clears the sticky error.
    pll_locked = 1'b1;
    do_req(3, 10, 4, 32'h0, 1'b1);
    check_eq("t6_err_cleared", 32'(cfg_err), 32'd0);
    seq_end();
    lock_bounce();
    wait_flag(lat);
    check_eq("t6_done", 32'(cfg_done), 32'd1);
    check_eq("t6_sb_empty", 32'(sb.size()), 32'd0);

    // Asynchronous reset in the middle of the M write.
    stall_len = 3;
    do_req(2, 74, 25, 32'h8000_0000, 1'b1);
    for (int i = 0; i < 100; i++) begin
      if (mgmt_write && mgmt_address == 6'h04) break;
      @(negedge clk);
    end
    check_eq("t7_reached_wr_m", 32'(mgmt_address), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t7_rst_write", 32'(mgmt_write), 32'd0);
    check_eq("t7_rst_busy", 32'(cfg_busy), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    stall_len = 0;
    do_req(2, 74, 25, 32'h8000_0000, 1'b1);
    seq_end();
    check_eq("t7_wr_cycles", 32'(wr_cycles), 32'd6);
    lock_bounce();
    wait_flag(lat);
    check_eq("t7_done", 32'(cfg_done), 32'd1);
    check_eq("t7_sb_empty", 32'(sb.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
